// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes, funct codes and the encoder's
// descriptor class / ALU-op encodings.
package mips_pkg;

    typedef enum logic [2:0] {
        KindR    = 3'd0,
        KindLw   = 3'd1,
        KindSw   = 3'd2,
        KindBeq  = 3'd3,
        KindAddi = 3'd4,
        KindJ    = 3'd5
    } kind_e;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluAnd = 3'd2,
        AluOr  = 3'd3,
        AluSlt = 3'd4
    } alu_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FunctAdd = 6'h20;
    localparam logic [5:0] FunctSub = 6'h22;
    localparam logic [5:0] FunctAnd = 6'h24;
    localparam logic [5:0] FunctOr  = 6'h25;
    localparam logic [5:0] FunctSlt = 6'h2A;

    function automatic logic alu_legal(input logic [2:0] alu);
        return alu <= 3'd4;
    endfunction

    function automatic logic [5:0] alu_funct(input logic [2:0] alu);
        logic [5:0] funct;
        case (alu_e'(alu))
            AluAdd:  funct = FunctAdd;
            AluSub:  funct = FunctSub;
            AluAnd:  funct = FunctAnd;
            AluOr:   funct = FunctOr;
            AluSlt:  funct = FunctSlt;
            default: funct = 6'h00;
        endcase
        return funct;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push when full and pop when
// empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    // Storage needs no reset; empty pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction descriptors into MIPS words, buffers them and writes
// them to instruction memory at consecutive word addresses.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int unsigned        FIFO_DEPTH = 4,
    parameter int unsigned        ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [2:0]        in_alu,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err
);

    localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(4);

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              accept, push, pop;
    logic              fifo_full, fifo_empty;
    logic [31:0]       fifo_rdata;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (kind_e'(in_kind))
            KindR: begin
                enc_legal = alu_legal(in_alu);
                enc_word  = {OpRtype, in_rs, in_rt, in_rd, 5'd0, alu_funct(in_alu)};
            end
            KindLw:   enc_word = {OpLw, in_rs, in_rt, in_imm};
            KindSw:   enc_word = {OpSw, in_rs, in_rt, in_imm};
            KindBeq:  enc_word = {OpBeq, in_rs, in_rt, in_imm};
            KindAddi: enc_word = {OpAddi, in_rs, in_rt, in_imm};
            KindJ:    enc_word = {OpJ, in_target};
            default:  enc_legal = 1'b0;
        endcase
    end

    // Illegal descriptors are consumed but never reach the FIFO.
    assign in_ready = ~fifo_full & ~rst;
    assign accept   = in_valid & in_ready;
    assign push     = accept & enc_legal;
    assign pop      = ~fifo_empty & mem_ready;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (enc_word),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= BASE_ADDR;
            err_q  <= 1'b0;
        end else begin
            if (pop)                  addr_q <= addr_q + AddrStep;
            if (accept && !enc_legal) err_q  <= 1'b1;
        end
    end

    assign mem_we    = ~fifo_empty;
    assign mem_wdata = fifo_empty ? 32'h0 : fifo_rdata;
    assign mem_addr  = addr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default instance plus an 8-bit-address
// instance sharing the same stimulus to exercise address wrap-around.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  in_kind = '0;
    logic [2:0]  in_alu = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        mem_ready = 1'b1;

    logic        in_ready, mem_we, err;
    logic [31:0] mem_addr, mem_wdata;
    logic        in_ready2, mem_we2, err2;
    logic [7:0]  mem_addr2;
    logic [31:0] mem_wdata2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] wr_addr[$], wr_data[$];
    int          wr_cyc[$];
    logic [7:0]  wr_addr2[$];

    always #5 clk = ~clk;

    instr_encoder u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_alu(in_alu), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .err(err)
    );

    instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(8), .BASE_ADDR(8'hFC)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_kind(in_kind), .in_alu(in_alu), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .mem_we(mem_we2), .mem_ready(mem_ready),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .err(err2)
    );

    // Record each write that completes at the following rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst && mem_we && mem_ready) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (!rst && mem_we2 && mem_ready) wr_addr2.push_back(mem_addr2);
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        wr_addr2.delete();
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_log();
    endtask

    task automatic drive(input logic [2:0] kind, input logic [2:0] alu, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                         input logic [25:0] tgt);
        in_kind = kind; in_alu = alu; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt; in_valid = 1'b1;
    endtask

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] kind, input logic [2:0] alu, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                        input logic [25:0] tgt);
        int n = 0;
        drive(kind, alu, rs, rt, rd, imm, tgt);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int k = 0;
        while (wr_data.size() < n && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (k >= 100) begin
            errors++;
            $display("FAIL write_timeout: writes=%0d, required %0d", wr_data.size(), n);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        checks += 6;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b, required 0", mem_we); end
        if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h, required 0", mem_wdata); end
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h, required 0", mem_addr); end
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, required 0", err); end
        if (mem_addr2 !== 8'hFC) begin errors++; $display("FAIL rst_addr8: got %h, required fc", mem_addr2); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b, required 1", in_ready); end
        @(posedge clk); #1;
        clear_log();
    endtask

    task automatic test_rtype_add();
        apply_reset();
        mem_ready = 1'b1;
        send(3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        checks += 2;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL add_latency_we: got %b, required 1", mem_we); end
        if (mem_wdata !== 32'h00221820) begin
            errors++; $display("FAIL add_latency_data: got %h, required 00221820", mem_wdata);
        end
        wait_writes(1);
        checks += 3;
        if (wr_data.size() != 1) begin errors++; $display("FAIL add_count: got %0d, required 1", wr_data.size()); end
        if (wr_data.size() > 0 && wr_data[0] !== 32'h00221820) begin
            errors++; $display("FAIL add_data: got %h, required 00221820", wr_data[0]);
        end
        if (wr_addr.size() > 0 && wr_addr[0] !== 32'h0) begin
            errors++; $display("FAIL add_addr: got %h, required 0", wr_addr[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data [5] = '{32'h8C080004, 32'hAC080008, 32'h1022FFFF,
                                      32'h20090005, 32'h08000010};
        apply_reset();
        mem_ready = 1'b1;
        send(3'd1, 3'd7, 5'd0, 5'd8, 5'd31, 16'h0004, 26'h0);
        send(3'd2, 3'd0, 5'd0, 5'd8, 5'd0, 16'h0008, 26'h0);
        send(3'd3, 3'd0, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        send(3'd4, 3'd0, 5'd0, 5'd9, 5'd0, 16'h0005, 26'h0);
        send(3'd5, 3'd0, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h10);
        wait_writes(5);
        checks++;
        if (wr_data.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d, required 5", wr_data.size()); end
        for (int i = 0; i < 5 && i < wr_data.size(); i++) begin
            checks += 3;
            if (wr_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL b2b_data[%0d]: got %h, required %h", i, wr_data[i], exp_data[i]);
            end
            if (wr_addr[i] !== 32'(4 * i)) begin
                errors++; $display("FAIL b2b_addr[%0d]: got %h, required %h", i, wr_addr[i], 4 * i);
            end
            if (wr_cyc[i] != wr_cyc[0] + i) begin
                errors++; $display("FAIL b2b_rate[%0d]: got cycle %0d, required %0d", i, wr_cyc[i], wr_cyc[0] + i);
            end
        end
    endtask

    task automatic test_full();
        apply_reset();
        mem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send(3'd4, 3'd0, 5'd0, 5'(k), 5'd0, 16'(k), 26'h0);
        drive(3'd4, 3'd0, 5'd0, 5'd5, 5'd0, 16'd5, 26'h0);
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b, required 0", in_ready); end
        if (mem_we !== 1'b1) begin errors++; $display("FAIL full_we: got %b, required 1", mem_we); end
        if (mem_wdata !== 32'h20010001) begin
            errors++; $display("FAIL full_hold_data: got %h, required 20010001", mem_wdata);
        end
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL full_hold_addr: got %h, required 0", mem_addr); end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL no_bypass: got %b, required 0", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL after_pop_ready: got %b, required 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_writes(5);
        checks++;
        if (wr_data.size() != 5) begin errors++; $display("FAIL full_count: got %0d, required 5", wr_data.size()); end
        for (int i = 0; i < 5 && i < wr_data.size(); i++) begin
            checks += 2;
            if (wr_data[i] !== (32'h20000000 | (32'(i + 1) << 16) | 32'(i + 1))) begin
                errors++; $display("FAIL full_data[%0d]: got %h", i, wr_data[i]);
            end
            if (wr_addr[i] !== 32'(4 * i)) begin
                errors++; $display("FAIL full_addr[%0d]: got %h, required %h", i, wr_addr[i], 4 * i);
            end
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        mem_ready = 1'b1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL ill_err_init: got %b, required 0", err); end
        send(3'd6, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        checks += 2;
        if (err !== 1'b1) begin errors++; $display("FAIL ill_err_set: got %b, required 1", err); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL ill_no_push: got %b, required 0", mem_we); end
        send(3'd0, 3'd7, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        send(3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        wait_writes(1);
        checks += 4;
        if (wr_data.size() != 1) begin errors++; $display("FAIL ill_count: got %0d, required 1", wr_data.size()); end
        if (wr_data.size() > 0 && wr_data[0] !== 32'h00221820) begin
            errors++; $display("FAIL ill_data: got %h, required 00221820", wr_data[0]);
        end
        if (wr_addr.size() > 0 && wr_addr[0] !== 32'h0) begin
            errors++; $display("FAIL ill_addr: got %h, required 0", wr_addr[0]);
        end
        if (err !== 1'b1) begin errors++; $display("FAIL ill_err_sticky: got %b, required 1", err); end
    endtask

    task automatic test_wrap();
        apply_reset();
        mem_ready = 1'b1;
        send(3'd0, 3'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        send(3'd5, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
        wait_writes(2);
        checks += 3;
        if (wr_addr2.size() != 2) begin errors++; $display("FAIL wrap_count: got %0d, required 2", wr_addr2.size()); end
        if (wr_addr2.size() > 1 && wr_addr2[0] !== 8'hFC) begin
            errors++; $display("FAIL wrap_addr0: got %h, required fc", wr_addr2[0]);
        end
        if (wr_addr2.size() > 1 && wr_addr2[1] !== 8'h00) begin
            errors++; $display("FAIL wrap_addr1: got %h, required 00", wr_addr2[1]);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mem_ready = 1'b1;
        send(3'd4, 3'd0, 5'd0, 5'd1, 5'd0, 16'h1, 26'h0);
        send(3'd4, 3'd0, 5'd0, 5'd2, 5'd0, 16'h2, 26'h0);
        wait_writes(2);
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(3'd4, 3'd0, 5'd0, 5'd3, 5'd0, 16'(k), 26'h0);
        checks += 2;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL mid_queued_we: got %b, required 1", mem_we); end
        if (mem_addr !== 32'h8) begin errors++; $display("FAIL mid_pre_addr: got %h, required 8", mem_addr); end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_we: got %b, required 0", mem_we); end
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL mid_addr: got %h, required 0", mem_addr); end
        if (mem_addr2 !== 8'hFC) begin errors++; $display("FAIL mid_addr8: got %h, required fc", mem_addr2); end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b1;
        clear_log();
        send(3'd0, 3'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        wait_writes(1);
        checks += 3;
        if (wr_data.size() != 1) begin errors++; $display("FAIL mid_count: got %0d, required 1", wr_data.size()); end
        if (wr_data.size() > 0 && wr_data[0] !== 32'h0022182A) begin
            errors++; $display("FAIL mid_data: got %h, required 0022182a", wr_data[0]);
        end
        if (wr_addr.size() > 0 && wr_addr[0] !== 32'h0) begin
            errors++; $display("FAIL mid_post_addr: got %h, required 0", wr_addr[0]);
        end
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_back_to_back();
        test_full();
        test_illegal();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and instruction-memory writer: the producer-side counterpart of the main control decoder. It accepts instruction descriptions (class, registers, immediate, target) over a valid/ready handshake and packs them into 32-bit MIPS words. It buffers the words in a small FIFO and writes them to instruction memory at consecutive word addresses. It is used to load programs and to generate opcode streams for the decoder and datapath benches.

## Interface
- FIFO_DEPTH, 4: output buffer entries; power of two, at least 2.
- ADDR_W, 32: memory address width.
- BASE_ADDR, 0: first write address; must be a multiple of 4.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  descriptor present
- in_ready  out  1  encoder can accept a descriptor
- in_kind  in  3  instruction class: 0 R-type, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J; 6 and 7 are illegal
- in_alu  in  3  R-type function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT; 5 to 7 are illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate or branch offset
- in_target  in  26  jump target
- mem_we  out  1  write request
- mem_ready  in  1  memory accepts the write this cycle
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  32  encoded instruction
- err  out  1  sticky illegal-descriptor flag

## Operation
- A descriptor is accepted when in_valid and in_ready are both high at a rising edge.
- Encoding is combinational from the descriptor. The encoded word is pushed into the FIFO at the accepting edge.
- R-type: opcode 000000, then rs, rt, rd, shamt 0, funct. Funct values: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
- I-type: opcode, rs, rt, imm. Opcodes: LW 100011, SW 101011, BEQ 000100, ADDI 001000.
- J: opcode 000010, then target.
- Fields not used by a class are ignored. in_alu is ignored for every class except R-type.
- Illegal descriptors:
  - An illegal in_kind, or an illegal in_alu on an R-type descriptor, is still handshaken (consumed).
  - Nothing is pushed to the FIFO.
  - err sets and stays high until rst.
- in_ready is high exactly when the FIFO is not full. There is no bypass: a pop does not free space in the same cycle for a push.
- Drain:
  - mem_we is high exactly when the FIFO is not empty.
  - mem_wdata is the FIFO head; mem_addr is the current write pointer.
  - When mem_we and mem_ready are both high at an edge, the head is popped and mem_addr advances by 4, modulo 2^ADDR_W.
- A simultaneous push and pop in the same edge is legal; the FIFO occupancy is unchanged.
- Words are written in the order they were accepted, with no gaps and no duplicates.

## Timing
- Reset values:
  - in_ready 0 while rst is asserted, then 1 at the first cycle after release.
  - mem_we 0, mem_wdata 0, mem_addr BASE_ADDR, err 0.
  - FIFO empty.
- Latency: a descriptor accepted at edge N into an empty FIFO appears on mem_we and mem_wdata in the cycle after edge N.
- Throughput: one word per cycle in steady state, with mem_ready held high.
- mem_we, mem_addr and mem_wdata stay stable while mem_we is high and mem_ready is low.
- Reset asserted mid-operation takes effect asynchronously:
  - all queued words are discarded;
  - mem_we drops immediately;
  - mem_addr returns to BASE_ADDR;
  - err clears.
- Full FIFO: in_ready stays low until the cycle after a pop.

## Structure
- The shared mips_pkg holds:
  - opcode constants (R-type, LW, SW, BEQ, ADDI, J), matching those used by the main decoder;
  - funct constants;
  - the in_kind and in_alu encodings.
- Sub-module sync_fifo, parameterised by WIDTH=32 and DEPTH=FIFO_DEPTH, with full and empty outputs. Pointers carry one extra wrap bit.
- The encoder logic and the address counter live in instr_encoder.

## Test plan
- R-type ADD with rs=1, rt=2, rd=3 -> one write: mem_wdata 0x00221820 at mem_addr 0x0.
- Back-to-back LW (rs=0, rt=8, imm=4), SW (rs=0, rt=8, imm=8), BEQ (rs=1, rt=2, imm=0xFFFF), ADDI (rs=0, rt=9, imm=5), J (target=0x10), with mem_ready high -> writes 0x8C080004, 0xAC080008, 0x1022FFFF, 0x20090005, 0x08000010 at addresses 0x0, 0x4, 0x8, 0xC, 0x10, one per cycle.
- mem_ready held low while offering 5 descriptors -> 4 accepted, then in_ready low. Release mem_ready -> 4 in-order writes, then the fifth is accepted and written at 0x10.
- in_kind=6, then R-type with in_alu=7, then a legal ADD -> only the ADD is written, at 0x0. err goes high after the first descriptor and stays high.
- ADDR_W=8 with BASE_ADDR=0xFC, two writes -> addresses 0xFC then 0x00 (wrap-around).
- rst pulsed while 3 words are queued -> mem_we 0 immediately and mem_addr equals BASE_ADDR. After release, the next accepted word is written at BASE_ADDR.
